// File: rtl/mul_hazard_ctrl_pkg.sv
// mul_hazard_ctrl_pkg: shared RISC-V register and mul-decode constants
package mul_hazard_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL = 3'b000;
endpackage

// File: rtl/mul_track_pipe.sv
// mul_track_pipe: valid/rd shift pipe of in-flight muls with address match against the youngest stages
module mul_track_pipe #(
  parameter int L = 3,
  parameter int AW = 5,
  parameter int NCMP = 2
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_load_valid,
  input  logic [AW-1:0]       i_load_rd,
  input  logic [2:0][AW-1:0]  i_cmp_addr,
  output logic [L-1:0]        o_vld,
  output logic [L-1:0][AW-1:0] o_rd,
  output logic [2:0]          o_hit
);
  logic [L-1:0]         r_vld;
  logic [L-1:0][AW-1:0] r_rd;
  // shift every clock; reset discards everything in flight
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld <= '0;
      r_rd  <= '0;
    end else begin
      r_vld <= {r_vld[L-2:0], i_load_valid};
      r_rd  <= {r_rd[L-2:0], i_load_rd};
    end
  end
  // match each lookup address against valid stages 0..NCMP-1 (last stage is bypassed)
  always_comb begin
    o_hit = '0;
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < NCMP; s++)
        if (r_vld[s] && r_rd[s] == i_cmp_addr[k]) o_hit[k] = 1'b1;
  end
  assign o_vld = r_vld;
  assign o_rd  = r_rd;
endmodule

// File: rtl/mul_hazard_ctrl.sv
// mul_hazard_ctrl: decode-side issue/hazard control for the fixed-latency pipelined multiplier
module mul_hazard_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int ALU_WB_DELAY = 1,
  parameter int REG_AW = mul_hazard_ctrl_pkg::REG_AW,
  localparam int CW = $clog2(MUL_LATENCY + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_id_valid,
  input  logic              i_id_is_mul,
  input  logic              i_id_writes_rd,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic              i_id_rs1_used,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs2_used,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_mul_issue,
  output logic              o_mul_wb_valid,
  output logic [REG_AW-1:0] o_mul_wb_rd,
  output logic              o_busy,
  output logic [CW-1:0]     o_inflight_count
);
  import mul_hazard_ctrl_pkg::*;
  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);
  logic                           w_live, w_accept_mul, w_raw, w_waw, w_wbc, w_load;
  logic [2:0]                     w_hit;
  logic [MUL_LATENCY-1:0]         w_vld;
  logic [MUL_LATENCY-1:0][REG_AW-1:0] w_rd;
  assign w_live = i_reset_n & i_id_valid & ~i_flush;
  assign w_raw = (i_id_rs1_used & (i_id_rs1 != X0) & w_hit[0]) |
                 (i_id_rs2_used & (i_id_rs2 != X0) & w_hit[1]);
  assign w_waw = i_id_writes_rd & (i_id_rd != X0) & w_hit[2];
  assign w_wbc = i_id_writes_rd & ~i_id_is_mul & w_vld[MUL_LATENCY-1-ALU_WB_DELAY];
  assign o_stall = w_live & (w_raw | w_waw | w_wbc);
  assign w_accept_mul = w_live & ~o_stall & i_id_is_mul;
  assign o_mul_issue = w_accept_mul;
  assign w_load = w_accept_mul & (i_id_rd != X0);
  mul_track_pipe #(.L(MUL_LATENCY), .AW(REG_AW), .NCMP(MUL_LATENCY-1)) u_pipe (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_load_valid (w_load),
    .i_load_rd    (w_load ? i_id_rd : X0),
    .i_cmp_addr   ({i_id_rd, i_id_rs2, i_id_rs1}),
    .o_vld        (w_vld),
    .o_rd         (w_rd),
    .o_hit        (w_hit)
  );
  assign o_mul_wb_valid = w_vld[MUL_LATENCY-1];
  assign o_mul_wb_rd = w_rd[MUL_LATENCY-1];
  assign o_busy = |w_vld;
  // number of tracked muls across all stages
  always_comb begin
    o_inflight_count = '0;
    for (int k = 0; k < MUL_LATENCY; k++) o_inflight_count = o_inflight_count + CW'(w_vld[k]);
  end
endmodule

// File: tb/tb_mul_hazard_ctrl.sv
// tb_mul_hazard_ctrl: table-driven stall/issue checks with a writeback scoreboard
module tb_mul_hazard_ctrl;
  localparam int L = 3;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       v = 0, m = 0, w = 0, u1 = 0, u2 = 0, f = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic       stall, issue, wbv, busy;
  logic [4:0] wbrd;
  logic [1:0] cnt;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic v, m, w; logic [4:0] rd, rs1; logic u1; logic [4:0] rs2; logic u2, f, st, is;} vec_t;
  typedef struct {int due; logic [4:0] rd;} sb_t;
  vec_t tbl[$];
  sb_t  q[$];

  mul_hazard_ctrl #(.MUL_LATENCY(L), .ALU_WB_DELAY(1), .REG_AW(5)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_id_valid(v), .i_id_is_mul(m), .i_id_writes_rd(w),
    .i_id_rd(rd), .i_id_rs1(rs1), .i_id_rs1_used(u1), .i_id_rs2(rs2), .i_id_rs2_used(u2),
    .i_flush(f), .o_stall(stall), .o_mul_issue(issue), .o_mul_wb_valid(wbv),
    .o_mul_wb_rd(wbrd), .o_busy(busy), .o_inflight_count(cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  function automatic vec_t mul(input int d, input int a, input int b, input bit st, input bit is, input bit fl = 0);
    vec_t r = '{1, 1, 1, 5'(d), 5'(a), 1, 5'(b), 1, fl, st, is};
    return r;
  endfunction

  function automatic vec_t alu(input int d, input int a, input bit ua, input int b, input bit ub, input bit st);
    vec_t r = '{1, 0, 1, 5'(d), 5'(a), ua, 5'(b), ub, 0, st, 0};
    return r;
  endfunction

  function automatic vec_t idle();
    vec_t r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    return r;
  endfunction

  task automatic drive(input vec_t t);
    v = t.v; m = t.m; w = t.w; rd = t.rd; rs1 = t.rs1; u1 = t.u1; rs2 = t.rs2; u2 = t.u2; f = t.f;
  endtask

  task automatic apply(input vec_t t);
    bit e;
    drive(t);
    #4;
    chk("stall", int'(stall), int'(t.st));
    chk("mul_issue", int'(issue), int'(t.is));
    e = q.size() > 0 && q[0].due == cyc;
    chk("inflight_count", int'(cnt), q.size());
    chk("busy", int'(busy), int'(q.size() > 0));
    chk("mul_wb_valid", int'(wbv), int'(e));
    if (e) begin
      chk("mul_wb_rd", int'(wbrd), int'(q[0].rd));
      void'(q.pop_front());
    end
    if (t.is && t.rd != 0) q.push_back('{cyc + L, t.rd});
    @(negedge clk);
    cyc++;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) tbl.push_back(idle());
  endtask

  initial begin
    // independent ops
    tbl.push_back(mul(11, 12, 13, 0, 1));
    tbl.push_back(alu(21, 20, 1, 0, 0, 0));
    idles(3);
    // dependent chain with last-stage bypass
    tbl.push_back(mul(11, 12, 13, 0, 1));
    tbl.push_back(mul(15, 11, 14, 1, 0));
    tbl.push_back(mul(15, 11, 14, 1, 0));
    tbl.push_back(mul(15, 11, 14, 0, 1));
    tbl.push_back(mul(17, 15, 16, 1, 0));
    tbl.push_back(mul(17, 15, 16, 1, 0));
    tbl.push_back(mul(17, 15, 16, 0, 1));
    idles(4);
    // writeback port conflict
    tbl.push_back(mul(11, 12, 13, 0, 1));
    tbl.push_back(idle());
    tbl.push_back(alu(5, 6, 1, 0, 0, 1));
    tbl.push_back(alu(5, 6, 1, 0, 0, 0));
    idles(2);
    // WAW then WAW+conflict
    tbl.push_back(mul(8, 1, 2, 0, 1));
    tbl.push_back(alu(8, 3, 1, 4, 1, 1));
    tbl.push_back(alu(8, 3, 1, 4, 1, 1));
    tbl.push_back(alu(8, 3, 1, 4, 1, 0));
    idles(2);
    // RAW on rs2, and unused rs1 does not stall
    tbl.push_back(mul(9, 1, 2, 0, 1));
    tbl.push_back(alu(10, 3, 1, 9, 1, 1));
    tbl.push_back(alu(10, 3, 1, 9, 1, 1));
    tbl.push_back(alu(10, 3, 1, 9, 1, 0));
    idles(2);
    tbl.push_back(mul(9, 1, 2, 0, 1));
    tbl.push_back(alu(10, 9, 0, 0, 0, 0));
    idles(3);
    // x0 destination is never tracked
    tbl.push_back(mul(0, 1, 2, 0, 1));
    tbl.push_back(alu(3, 0, 1, 0, 1, 0));
    idles(3);
    // flush kills decode but not in-flight work
    tbl.push_back(mul(11, 12, 13, 0, 1));
    tbl.push_back(mul(15, 11, 14, 0, 0, 1));
    idles(3);

    // reset state, with a mul presented while reset is low
    drive(mul(11, 12, 13, 0, 0));
    @(negedge clk);
    #4;
    chk("rst_stall", int'(stall), 0);
    chk("rst_issue", int'(issue), 0);
    chk("rst_wbv", int'(wbv), 0);
    chk("rst_wbrd", int'(wbrd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt), 0);
    drive(idle());
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);
    chk("drained", q.size(), 0);

    // reset mid-flight: two muls, async reset in the third cycle
    apply(mul(11, 12, 13, 0, 1));
    apply(mul(12, 1, 2, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", int'(cnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wbv", int'(wbv), 0);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_wbv", int'(wbv), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(mul(20, 1, 2, 0, 1));
    apply(mul(21, 20, 2, 1, 0));
    apply(mul(21, 20, 2, 1, 0));
    apply(mul(21, 20, 2, 0, 1));
    for (int i = 0; i < 4; i++) apply(idle());
    chk("final_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
